clk_monitor: RTL and testbench
==============================

Name: clk_monitor

Overview:
Synthesizable measurement stage downstream of the configurable clock generator. It samples the generator's reference and phase-shifted outputs on a faster system clock and reports, for every reference period, the period, the high time and the rising-edge lag of the phase clock. All results are in system-clock cycles. It is used for on-chip checking of the generator's frequency, duty-cycle and phase settings.

Parameters:
CNT_W, 16, width of all measurement counters and result outputs.
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (legal 2..4).
TIMEOUT, 1000, system cycles without a reference rise before the stall flag is raised (must be < 2^CNT_W).

Ports:
clk  input  1  system sampling clock.
rst  input  1  synchronous, active-high reset.
en  input  1  monitor enable; low forces IDLE.
mon_ref  input  1  asynchronous reference clock under test.
mon_phase  input  1  asynchronous phase-shifted clock under test.
period_out  output  CNT_W  cycles between consecutive ref rises.
high_out  output  CNT_W  cycles from ref rise to ref fall.
phase_out  output  CNT_W  cycles from ref rise to the next phase rise.
meas_valid  output  1  one-cycle pulse when the outputs update.
phase_miss  output  1  no phase rise occurred within the measured period.
ovf  output  1  a counter saturated during the measured period.
stalled  output  1  ref has been idle for at least TIMEOUT cycles.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0, synchronizers cleared.
- Each input passes through SYNC_STAGES flip-flops plus one history register.
- rise = sync & ~hist; fall = ~sync & hist.
- Edge pulses therefore trail the input by SYNC_STAGES+1 cycles. Every distance below is measured between detect pulses.
- FSM states:
  - IDLE: counters held at 0. If en=1, go to ARM next cycle.
  - ARM: wait for ref rise. On rise, go to MEAS and start the period.
  - MEAS: measure continuously until en=0 or timeout.
- en=0 in any state: go to IDLE next cycle. The current measurement is discarded. period/high/phase outputs hold their last values. meas_valid=0; stalled is cleared.
- Counters in MEAS:
  - Set to 1 in the cycle after a ref rise; increment by 1 each cycle after that.
  - A ref rise at counter value N means period = N.
  - high = counter value at the ref fall. phase = counter value at the first phase rise after the ref rise.
  - A phase rise in the same cycle as a ref rise belongs to the new period, with phase = 0.
  - Later phase rises within the same period are ignored.
- Ref rise in MEAS (not the first rise after ARM):
  - In the next cycle, register period_out, high_out and phase_out, and pulse meas_valid for 1 cycle.
  - If no phase rise occurred: phase_out = period, phase_miss = 1.
  - If no ref fall occurred: high_out = period.
  - ovf reflects saturation during that period.
  - phase_miss and ovf are updated only with meas_valid.
- Saturation: counters stop at 2^CNT_W-1 and do not wrap; ovf is set for that period.
- Timeout:
  - In MEAS, if TIMEOUT cycles pass since the last ref rise: go to ARM, stalled=1, no meas_valid.
  - stalled clears on the next meas_valid, on en=0, or on rst.
  - In ARM, stalled stays set until the next valid measurement completes.
- rst has priority over en and over all edge events. Reset mid-measurement discards the partial results; the first meas_valid after reset needs two ref rises.
- No division is performed; duty = high_out/period_out is computed by software or the bench.

Test Plan:
- Steady 50%: ref period 10 clk, high 5, phase rises 4 cycles after ref, en=1 -> from the 2nd ref rise onward, each period gives period_out=10, high_out=5, phase_out=4, meas_valid 1-cycle pulse, phase_miss=0, ovf=0.
- Duty change: same ref with high 3 -> high_out=3, period_out=10.
- Missing phase: mon_phase held low -> phase_out=10, phase_miss=1 every period.
- Stall: ref stops after 3 periods, TIMEOUT=1000 -> stalled=1 exactly 1000 cycles after the last rise detect, no further meas_valid. Restart ref -> stalled clears on the next meas_valid.
- Overflow: CNT_W=4, ref period 20 -> period_out=15, ovf=1.
- Reset mid-measure: rst for 1 cycle in mid-period -> all outputs 0. First meas_valid comes one full period after the first post-reset ref rise. en=0 pulse -> outputs held, stalled=0.

Source files
------------

// File: rtl/clk_monitor.sv
// Measures period, high time and phase lag of two asynchronous clocks in
// system-clock cycles, one result set per reference period.
module clk_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_ref,
  input  logic             mon_phase,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] phase_out,
  output logic             meas_valid,
  output logic             phase_miss,
  output logic             ovf,
  output logic             stalled,
  output logic [1:0]       fsm_state
);

  // Stall detection has its own counter so it is independent of CNT_W saturation.
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] ref_sync_q, ph_sync_q;
  logic                   ref_hist_q, ph_hist_q;
  logic                   ref_rise, ref_fall, ph_rise;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic             high_seen_q, high_seen_d;
  logic [CNT_W-1:0] ph_cap_q, ph_cap_d;
  logic             ph_seen_q, ph_seen_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             valid_q, valid_d;
  logic             miss_q, miss_d;
  logic             ovf_q, ovf_d;
  logic             stalled_q, stalled_d;
  logic             start_period;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sync_q <= '0;
      ph_sync_q  <= '0;
      ref_hist_q <= 1'b0;
      ph_hist_q  <= 1'b0;
    end else begin
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], mon_ref};
      ph_sync_q  <= {ph_sync_q[SYNC_STAGES-2:0], mon_phase};
      ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
      ph_hist_q  <= ph_sync_q[SYNC_STAGES-1];
    end
  end

  assign ref_rise = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q;
  assign ref_fall = ~ref_sync_q[SYNC_STAGES-1] & ref_hist_q;
  assign ph_rise  = ph_sync_q[SYNC_STAGES-1] & ~ph_hist_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    high_cap_d   = high_cap_q;
    high_seen_d  = high_seen_q;
    ph_cap_d     = ph_cap_q;
    ph_seen_d    = ph_seen_q;
    sat_d        = sat_q;
    period_d     = period_q;
    high_d       = high_q;
    phase_d      = phase_q;
    valid_d      = 1'b0;
    miss_d       = miss_q;
    ovf_d        = ovf_q;
    stalled_d    = stalled_q;
    start_period = 1'b0;

    if (!en) begin
      state_d     = IDLE;
      cnt_d       = '0;
      to_d        = '0;
      high_seen_d = 1'b0;
      ph_seen_d   = 1'b0;
      sat_d       = 1'b0;
      stalled_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          to_d    = '0;
          state_d = ARM;
        end
        ARM: begin
          if (ref_rise) begin
            state_d      = MEAS;
            start_period = 1'b1;
          end
        end
        MEAS: begin
          if (ref_rise) begin
            // Missing fall or phase edge reports the full period instead.
            period_d     = cnt_q;
            high_d       = high_seen_q ? high_cap_q : cnt_q;
            phase_d      = ph_seen_q ? ph_cap_q : cnt_q;
            miss_d       = ~ph_seen_q;
            ovf_d        = sat_q;
            valid_d      = 1'b1;
            stalled_d    = 1'b0;
            start_period = 1'b1;
          end else if (to_q >= TO_LAST) begin
            state_d   = ARM;
            stalled_d = 1'b1;
            cnt_d     = '0;
            to_d      = '0;
          end else begin
            to_d = to_q + TO_W'(1);
            if (cnt_q == CNT_MAX) begin
              sat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (ref_fall && !high_seen_q) begin
              high_cap_d  = cnt_q;
              high_seen_d = 1'b1;
            end
            if (ph_rise && !ph_seen_q) begin
              ph_cap_d  = cnt_q;
              ph_seen_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A phase edge coincident with the ref rise belongs to the new period.
    if (start_period) begin
      cnt_d       = CNT_W'(1);
      to_d        = TO_W'(1);
      high_seen_d = 1'b0;
      ph_seen_d   = ph_rise;
      ph_cap_d    = '0;
      sat_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      high_cap_q  <= '0;
      high_seen_q <= 1'b0;
      ph_cap_q    <= '0;
      ph_seen_q   <= 1'b0;
      sat_q       <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      miss_q      <= 1'b0;
      ovf_q       <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      high_cap_q  <= high_cap_d;
      high_seen_q <= high_seen_d;
      ph_cap_q    <= ph_cap_d;
      ph_seen_q   <= ph_seen_d;
      sat_q       <= sat_d;
      period_q    <= period_d;
      high_q      <= high_d;
      phase_q     <= phase_d;
      valid_q     <= valid_d;
      miss_q      <= miss_d;
      ovf_q       <= ovf_d;
      stalled_q   <= stalled_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign phase_out  = phase_q;
  assign meas_valid = valid_q;
  assign phase_miss = miss_q;
  assign ovf        = ovf_q;
  assign stalled    = stalled_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: timestamp-based reference model compared every cycle,
// plus literal checks of the key scenarios and a narrow-counter instance.
module tb_clk_monitor;

  localparam int CNT_W = 16;
  localparam int S     = 2;
  localparam int TO    = 1000;
  localparam int MAXV  = (1 << CNT_W) - 1;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst, en, mon_ref, mon_phase, ref2;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CNT_W-1:0] period_out, high_out, phase_out;
  logic             meas_valid, phase_miss, ovf, stalled;
  logic [1:0]       fsm_state;

  logic [3:0] p4, h4, ph4;
  logic       v4, m4, o4, s4;
  logic [1:0] fs4;
  logic       zero_phase = 1'b0;

  clk_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .mon_ref(mon_ref), .mon_phase(mon_phase),
    .period_out(period_out), .high_out(high_out), .phase_out(phase_out),
    .meas_valid(meas_valid), .phase_miss(phase_miss), .ovf(ovf),
    .stalled(stalled), .fsm_state(fsm_state)
  );

  clk_monitor #(.CNT_W(4), .SYNC_STAGES(S), .TIMEOUT(TO)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mon_ref(ref2), .mon_phase(zero_phase),
    .period_out(p4), .high_out(h4), .phase_out(ph4),
    .meas_valid(v4), .phase_miss(m4), .ovf(o4),
    .stalled(s4), .fsm_state(fs4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int last_rise_cyc = 0;

  // Reference model: measurements are differences of detect-cycle timestamps.
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2;
  int m_mode, mc, k0, kf, kp;
  logic dl_r [0:S];
  logic dl_p [0:S];
  logic [CNT_W-1:0] e_period, e_high, e_phase;
  logic e_valid, e_miss, e_ovf, e_stall;

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > MAXV) ? CNT_W'(MAXV) : CNT_W'(v);
  endfunction

  always @(posedge clk) begin : model
    logic rr, rf, pr;
    int per;
    rr = dl_r[S-1] & ~dl_r[S];
    rf = ~dl_r[S-1] & dl_r[S];
    pr = dl_p[S-1] & ~dl_p[S];
    e_valid = 1'b0;
    if (rst) begin
      m_mode = M_IDLE;
      e_period = '0; e_high = '0; e_phase = '0;
      e_miss = 1'b0; e_ovf = 1'b0; e_stall = 1'b0;
    end else if (!en) begin
      m_mode  = M_IDLE;
      e_stall = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: m_mode = M_ARM;
        M_ARM: if (rr) begin
          m_mode = M_MEAS;
          k0 = mc; kf = -1; kp = pr ? mc : -1;
        end
        default: begin
          if (rr) begin
            per      = mc - k0;
            e_period = sat(per);
            e_high   = (kf >= 0) ? sat(kf - k0) : sat(per);
            e_phase  = (kp >= 0) ? sat(kp - k0) : sat(per);
            e_miss   = (kp < 0);
            e_ovf    = (per > MAXV);
            e_valid  = 1'b1;
            e_stall  = 1'b0;
            k0 = mc; kf = -1; kp = pr ? mc : -1;
          end else begin
            if (rf && kf < 0) kf = mc;
            if (pr && kp < 0) kp = mc;
            // Stall shows exactly TO cycles after the last rise detect.
            if (mc - k0 >= TO - 1) begin
              m_mode  = M_ARM;
              e_stall = 1'b1;
            end
          end
        end
      endcase
    end
    for (int i = S; i > 0; i--) begin
      dl_r[i] = rst ? 1'b0 : dl_r[i-1];
      dl_p[i] = rst ? 1'b0 : dl_p[i-1];
    end
    dl_r[0] = rst ? 1'b0 : mon_ref;
    dl_p[0] = rst ? 1'b0 : mon_phase;
    mc++;
  end

  // Scoreboard: every cycle after the first reset
  always @(negedge clk) begin
    if (chk_on) begin
      n_checks++;
      if ({period_out, high_out, phase_out, meas_valid, phase_miss, ovf, stalled} !==
          {e_period, e_high, e_phase, e_valid, e_miss, e_ovf, e_stall}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL cycle_compare cyc=%0d got per=%0d hi=%0d ph=%0d v=%b pm=%b ovf=%b st=%b required per=%0d hi=%0d ph=%0d v=%b pm=%b ovf=%b st=%b",
                   cyc, period_out, high_out, phase_out, meas_valid, phase_miss, ovf, stalled,
                   e_period, e_high, e_phase, e_valid, e_miss, e_ovf, e_stall);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic run_periods(input int n, input int per, input int hi,
                             input int ph_off, input bit ph_en);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        mon_ref   = (i < hi);
        mon_phase = ph_en && (((i - ph_off + per) % per) < per / 2);
        if (i == 0) last_rise_cyc = cyc;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mon_ref   = 1'b0;
      mon_phase = 1'b0;
    end
  endtask

  // Narrow instance sees a free-running 20-cycle reference, high 10.
  initial begin
    ref2 = 1'b0;
    forever begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        ref2 = (i < 10);
      end
    end
  end

  initial begin
    int t_det;
    rst = 1'b1; en = 1'b0; mon_ref = 1'b0; mon_phase = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_period", period_out, 0);
    check("reset_valid", meas_valid, 0);
    check("reset_stalled", stalled, 0);
    chk_on = 1'b1;
    rst = 1'b0;
    en  = 1'b1;

    run_periods(10, 10, 5, 4, 1'b1);
    check("steady_period", period_out, 10);
    check("steady_high", high_out, 5);
    check("steady_phase", phase_out, 4);
    check("steady_miss", phase_miss, 0);
    check("ovf4_period", p4, 15);
    check("ovf4_high", h4, 10);
    check("ovf4_phase", ph4, 15);
    check("ovf4_miss", m4, 1);
    check("ovf4_flag", o4, 1);

    run_periods(6, 10, 3, 4, 1'b1);
    check("duty_high", high_out, 3);
    check("duty_period", period_out, 10);

    run_periods(6, 10, 5, 4, 1'b0);
    check("miss_phase", phase_out, 10);
    check("miss_flag", phase_miss, 1);

    // Stall: three periods then silence
    run_periods(3, 10, 5, 4, 1'b1);
    t_det = last_rise_cyc + S;
    while (cyc < t_det + TO - 1) idle_cycles(1);
    check("stall_not_early", stalled, 0);
    idle_cycles(1);
    check("stall_on_time", stalled, 1);
    idle_cycles(5);

    en = 1'b0;
    idle_cycles(3);
    en = 1'b1;
    check("enpulse_stall_clear", stalled, 0);
    check("enpulse_held_period", period_out, 10);
    check("enpulse_held_high", high_out, 5);
    check("enpulse_held_phase", phase_out, 4);

    run_periods(4, 10, 5, 4, 1'b1);
    t_det = last_rise_cyc + S;
    while (cyc < t_det + TO + 2) idle_cycles(1);
    check("stall2_set", stalled, 1);
    run_periods(3, 10, 2, 7, 1'b1);
    check("restart_stall_clear", stalled, 0);
    check("restart_high", high_out, 2);
    check("restart_phase", phase_out, 7);

    // Reset in the middle of a period
    fork
      run_periods(5, 10, 5, 4, 1'b1);
      begin
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_period", period_out, 0);
        check("midrst_high", high_out, 0);
        check("midrst_phase", phase_out, 0);
      end
    join

    // Randomized periods, duty, phase, with occasional en drops and resets
    for (int it = 0; it < 150; it++) begin
      int per, hi, ph;
      per = $urandom_range(3, 40);
      hi  = $urandom_range(1, per - 1);
      ph  = $urandom_range(0, per - 1);
      run_periods($urandom_range(1, 3), per, hi, ph, ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 15) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        en = 1'b1;
      end
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    idle_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
